// File: rtl/k12a_lcd_ctrl.sv
// k12a_lcd_ctrl: HD44780-style character LCD transfer engine.
// Buffers {rs, byte} writes in a small FIFO and replays each one to the panel
// with guaranteed setup, enable-pulse, hold and execution-wait timing.
// Ports:
//   cpu_clock, reset_n          : clock, async active-low reset
//   wr_valid, wr_rs, wr_data    : push request and payload
//   full, busy, overflow        : FIFO full, engine/FIFO busy, sticky drop flag
//   overflow_clr                : clears overflow (wins over a same-cycle set)
//   lcd_rs, lcd_rw, lcd_en,
//   lcd_data                    : panel interface (lcd_rw tied low)
module k12a_lcd_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned EN_CYCLES    = 2,
    parameter int unsigned HOLD_CYCLES  = 1,
    parameter int unsigned SHORT_WAIT   = 40,
    parameter int unsigned LONG_WAIT    = 1600,
    parameter int unsigned POWERON_WAIT = 15000
) (
    input  logic       cpu_clock,
    input  logic       reset_n,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned MAX_1  = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
    localparam int unsigned MAX_2  = (MAX_1 > HOLD_CYCLES) ? MAX_1 : HOLD_CYCLES;
    localparam int unsigned MAX_3  = (MAX_2 > SHORT_WAIT) ? MAX_2 : SHORT_WAIT;
    localparam int unsigned MAX_4  = (MAX_3 > LONG_WAIT) ? MAX_3 : LONG_WAIT;
    localparam int unsigned MAX_P  = (MAX_4 > POWERON_WAIT) ? MAX_4 : POWERON_WAIT;
    localparam int unsigned TMR_W  = $clog2(MAX_P) + 1;
    localparam int unsigned ENT_W  = 9;

    typedef enum logic [2:0] {
        S_POWERON = 3'd0,
        S_IDLE    = 3'd1,
        S_SETUP   = 3'd2,
        S_PULSE   = 3'd3,
        S_HOLD    = 3'd4,
        S_WAIT    = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic               w_tmr_zero;
    logic               w_en_nxt;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [ENT_W-1:0]   w_rd_entry;
    logic               w_rd_long;

    logic               r_full;
    logic               r_busy;
    logic               r_overflow;
    logic               r_lcd_rs;
    logic               r_lcd_en;
    logic [7:0]         r_lcd_data;
    logic               r_is_long;

    // FIFO head and clear/home decode (0x01 clear, 0x02/0x03 home)
    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_rd_long  = ~w_rd_entry[8] &
                        ((w_rd_entry[7:0] == 8'h01) | (w_rd_entry[7:1] == 7'h01));
    assign w_tmr_zero = (r_tmr == '0);

    // A pop on the same edge frees a slot, so a push into a full FIFO is accepted
    assign w_push = wr_valid & (~r_full | w_pop);
    assign w_drop = wr_valid & r_full & ~w_pop;

    // Occupancy update
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Next-state, timer and enable strobe
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_en_nxt    = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_POWERON: begin
                if (w_tmr_zero) w_state_nxt = S_IDLE;
                else            w_tmr_nxt   = r_tmr - TMR_W'(1);
            end
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_tmr_nxt   = TMR_W'(SETUP_CYCLES - 1);
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_tmr_zero) begin
                    w_tmr_nxt   = TMR_W'(EN_CYCLES - 1);
                    w_en_nxt    = 1'b1;
                    w_state_nxt = S_PULSE;
                end else begin
                    w_tmr_nxt   = r_tmr - TMR_W'(1);
                end
            end
            S_PULSE: begin
                if (w_tmr_zero) begin
                    w_tmr_nxt   = TMR_W'(HOLD_CYCLES - 1);
                    w_state_nxt = S_HOLD;
                end else begin
                    w_en_nxt    = 1'b1;
                    w_tmr_nxt   = r_tmr - TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (w_tmr_zero) begin
                    w_tmr_nxt   = r_is_long ? TMR_W'(LONG_WAIT - 1) : TMR_W'(SHORT_WAIT - 1);
                    w_state_nxt = S_WAIT;
                end else begin
                    w_tmr_nxt   = r_tmr - TMR_W'(1);
                end
            end
            S_WAIT: begin
                if (w_tmr_zero) w_state_nxt = S_IDLE;
                else            w_tmr_nxt   = r_tmr - TMR_W'(1);
            end
            default: begin
                w_state_nxt = S_POWERON;
                w_tmr_nxt   = TMR_W'(POWERON_WAIT - 1);
            end
        endcase
    end

    // State, timer and panel output registers
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_POWERON;
            r_tmr      <= TMR_W'(POWERON_WAIT - 1);
            r_lcd_en   <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_lcd_data <= 8'h00;
            r_is_long  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tmr    <= w_tmr_nxt;
            r_lcd_en <= w_en_nxt;
            if (w_pop) begin
                r_lcd_rs   <= w_rd_entry[8];
                r_lcd_data <= w_rd_entry[7:0];
                r_is_long  <= w_rd_long;
            end
        end
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_busy  <= (w_state_nxt != S_IDLE) | (w_count_nxt != '0);
            if (overflow_clr) r_overflow <= 1'b0;
            else if (w_drop)  r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are only read when occupancy says they are valid
    always_ff @(posedge cpu_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= {wr_rs, wr_data};
    end

    assign full     = r_full;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign lcd_rs   = r_lcd_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = r_lcd_en;
    assign lcd_data = r_lcd_data;

endmodule
